// File: rtl/boreal_pkg.sv
// ============================================================================
// Module      : boreal_pkg
// Description : Shared constants and FSM encoding for the PRIV-region slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package boreal_pkg;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hB0EA_1001;
    localparam logic [3:0]  PRIV_BASE        = 4'h2;
    localparam int          SCRATCH_NUM      = 5;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_SCRATCH0 = 5'h04;
    localparam logic [4:0] OFF_SCRATCH1 = 5'h08;
    localparam logic [4:0] OFF_SCRATCH2 = 5'h0C;
    localparam logic [4:0] OFF_SCRATCH3 = 5'h10;
    localparam logic [4:0] OFF_SCRATCH4 = 5'h14;
    localparam logic [4:0] OFF_VIOL     = 5'h18;
    localparam logic [4:0] OFF_ID       = 5'h1C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/boreal_priv_slave.sv
// ============================================================================
// Module      : boreal_priv_slave
// Description : Gate-only privileged register slave with wait states, lock
//               and violation counting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boreal_priv_slave
    import boreal_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        req,
    input  logic        is_gate,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        locked
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t                         state_q, state_d;
    logic [3:0]                     cnt_q, cnt_d;
    logic [31:0]                    req_addr_q, req_addr_d;
    logic                           req_we_q, req_we_d;
    logic [31:0]                    req_wdata_q, req_wdata_d;
    logic                           req_gate_q, req_gate_d;
    logic [31:0]                    ctrl_q, ctrl_d;
    logic [SCRATCH_NUM-1:0][31:0]   scratch_q, scratch_d;
    logic [7:0]                     viol_q, viol_d;

    logic [4:0]  off;
    logic        bad_range;
    logic        ro_or_locked;
    logic        resp_err;
    logic [31:0] rd_word;

    assign off          = req_addr_q[4:0];
    assign bad_range    = (req_addr_q[1:0] != 2'b00) || (req_addr_q[31:28] != PRIV_BASE)
                          || (req_addr_q[27:5] != 23'd0);
    assign ro_or_locked = req_we_q && ((off == OFF_VIOL) || (off == OFF_ID) || ctrl_q[0]);
    // Precedence is implicit: any of the three causes an error, but only
    // the non-gate case touches VIOL (handled in the commit below).
    assign resp_err     = !req_gate_q || bad_range || ro_or_locked;

    always_comb begin
        rd_word = '0;
        case (off)
            OFF_CTRL:     rd_word = ctrl_q;
            OFF_SCRATCH0: rd_word = scratch_q[0];
            OFF_SCRATCH1: rd_word = scratch_q[1];
            OFF_SCRATCH2: rd_word = scratch_q[2];
            OFF_SCRATCH3: rd_word = scratch_q[3];
            OFF_SCRATCH4: rd_word = scratch_q[4];
            OFF_VIOL:     rd_word = {24'd0, viol_q};
            OFF_ID:       rd_word = ID_VALUE;
            default:      rd_word = '0;
        endcase
    end

    assign ack    = (state_q == ST_RESP);
    assign err    = ack && resp_err;
    assign rdata  = (ack && !resp_err && !req_we_q) ? rd_word : 32'd0;
    assign locked = ctrl_q[0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_addr_d  = req_addr_q;
        req_we_d    = req_we_q;
        req_wdata_d = req_wdata_q;
        req_gate_d  = req_gate_q;
        ctrl_d      = ctrl_q;
        scratch_d   = scratch_q;
        viol_d      = viol_q;
        case (state_q)
            ST_IDLE: begin
                if (sel && req) begin
                    req_addr_d  = addr;
                    req_we_d    = we;
                    req_wdata_d = wdata;
                    req_gate_d  = is_gate;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                // Side effects land on the edge that closes the ack cycle.
                if (!req_gate_q) begin
                    viol_d = (viol_q == 8'hFF) ? viol_q : viol_q + 8'd1;
                end else if (!resp_err && req_we_q) begin
                    case (off)
                        OFF_CTRL:     ctrl_d = {req_wdata_q[31:1], ctrl_q[0] | req_wdata_q[0]};
                        OFF_SCRATCH0: scratch_d[0] = req_wdata_q;
                        OFF_SCRATCH1: scratch_d[1] = req_wdata_q;
                        OFF_SCRATCH2: scratch_d[2] = req_wdata_q;
                        OFF_SCRATCH3: scratch_d[3] = req_wdata_q;
                        OFF_SCRATCH4: scratch_d[4] = req_wdata_q;
                        default:      ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            req_gate_q  <= 1'b0;
            ctrl_q      <= '0;
            scratch_q   <= '0;
            viol_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
            req_gate_q  <= req_gate_d;
            ctrl_q      <= ctrl_d;
            scratch_q   <= scratch_d;
            viol_q      <= viol_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_boreal_priv_slave.sv
// ============================================================================
// Module      : tb_boreal_priv_slave
// Description : Self-checking bench for boreal_priv_slave (WAIT_CYCLES 2 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boreal_priv_slave;

    localparam logic [31:0] ID = 32'hB0EA_1001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0, req = 1'b0, is_gate = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        ack, err, locked;
    logic [31:0] rdata;

    logic        sel0 = 1'b0, req0 = 1'b0, is_gate0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic        ack0, err0, locked0;
    logic [31:0] rdata0;

    int errors = 0;
    int checks = 0;

    // Reference state: plain register image of the slave.
    logic [31:0] m_ctrl;
    logic [31:0] m_scr [5];
    int          m_viol;

    always #5 clk = ~clk;

    boreal_priv_slave #(.WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .req(req), .is_gate(is_gate),
        .addr(addr), .we(we), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata), .locked(locked)
    );

    boreal_priv_slave #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sel(sel0), .req(req0), .is_gate(is_gate0),
        .addr(addr0), .we(we0), .wdata(wdata0),
        .ack(ack0), .err(err0), .rdata(rdata0), .locked(locked0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0;
        for (int i = 0; i < 5; i++) m_scr[i] = '0;
        m_viol = 0;
    endtask

    task automatic model_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic g, output logic e, output logic [31:0] r);
        int idx;
        e = 1'b0;
        r = '0;
        idx = int'(a[4:2]);
        if (!g) begin
            e = 1'b1;
            if (m_viol < 255) m_viol++;
        end else if (a[1:0] != 2'b00 || a < 32'h2000_0000 || a > 32'h2000_001F) begin
            e = 1'b1;
        end else if (w) begin
            if (m_ctrl[0] || idx >= 6) e = 1'b1;
            else if (idx == 0) m_ctrl = {d[31:1], m_ctrl[0] | d[0]};
            else m_scr[idx-1] = d;
        end else begin
            if (idx == 0) r = m_ctrl;
            else if (idx <= 5) r = m_scr[idx-1];
            else if (idx == 6) r = 32'(m_viol);
            else r = ID;
        end
    endtask

    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic g, input string tag);
        int          lat;
        logic        e_obs, e_exp;
        logic [31:0] r_obs, r_exp;
        lat = 99;
        e_obs = 1'b0;
        r_obs = '0;
        @(negedge clk);
        sel = 1'b1; req = 1'b1; addr = a; we = w; wdata = d; is_gate = g;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = k; e_obs = err; r_obs = rdata;
                break;
            end
        end
        @(negedge clk);
        sel = 1'b0; req = 1'b0; addr = $urandom; we = $urandom_range(0, 1); wdata = $urandom;
        @(posedge clk); #1;
        model_access(a, w, d, g, e_exp, r_exp);
        chk({tag, ".lat"}, 32'(lat), 32'd3);
        chk({tag, ".err"}, {31'd0, e_obs}, {31'd0, e_exp});
        chk({tag, ".rdata"}, r_obs, r_exp);
        chk({tag, ".ack1"}, {31'd0, ack}, 32'd0);
        chk({tag, ".locked"}, {31'd0, locked}, {31'd0, m_ctrl[0]});
    endtask

    initial begin : main
        logic [31:0] a, d;
        int          lat1, lat2, seen;
        logic        e1, e2;

        model_reset();
        #12;
        chk("rst.ack", {31'd0, ack}, 32'd0);
        chk("rst.err", {31'd0, err}, 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.locked", {31'd0, locked}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        txn(32'h2000_0004, 1'b1, 32'h1234_5678, 1'b1, "wr_scr0");
        txn(32'h2000_0004, 1'b0, 32'h0, 1'b1, "rd_scr0");
        chk("rd_scr0.const", m_scr[0], 32'h1234_5678);
        txn(32'h2000_001C, 1'b0, 32'h0, 1'b0, "ng_rd_id");
        txn(32'h2000_0018, 1'b0, 32'h0, 1'b1, "rd_viol1");
        txn(32'h2000_001C, 1'b0, 32'h0, 1'b1, "rd_id");
        txn(32'h2000_0002, 1'b0, 32'h0, 1'b1, "rd_misal");
        txn(32'h2000_0020, 1'b0, 32'h0, 1'b1, "rd_range");
        txn(32'h2000_0018, 1'b0, 32'h0, 1'b1, "rd_viol_same");
        txn(32'h2000_0018, 1'b1, 32'h5, 1'b1, "wr_viol");
        txn(32'h2000_001C, 1'b1, 32'h5, 1'b1, "wr_id");

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 99) < 85) a = {27'h100_0000, 3'($urandom_range(0, 7)), 2'b00};
            else if ($urandom_range(0, 1) == 1) a = {27'h100_0000, 3'($urandom_range(0, 7)), 2'($urandom_range(1, 3))};
            else a = $urandom | 32'h4000_0000;
            d = $urandom;
            if (a[4:0] == 5'h00) d[0] = 1'b0;
            txn(a, 1'($urandom_range(0, 1)), d, ($urandom_range(0, 4) != 0), "rand");
        end

        for (int n = 0; n < 300; n++) begin
            txn(32'h2000_001C, 1'b0, 32'h0, 1'b0, "ng_sat");
        end
        txn(32'h2000_0018, 1'b0, 32'h0, 1'b1, "rd_viol_sat");
        chk("viol_sat.const", 32'(m_viol), 32'd255);

        txn(32'h2000_0000, 1'b1, 32'h0000_0001, 1'b1, "wr_lock");
        txn(32'h2000_0004, 1'b1, 32'hFFFF_FFFF, 1'b1, "wr_locked");
        txn(32'h2000_0000, 1'b1, 32'h0000_0000, 1'b1, "wr_ctrl_locked");
        txn(32'h2000_0004, 1'b0, 32'h0, 1'b1, "rd_after_lock");
        txn(32'h2000_0000, 1'b0, 32'h0, 1'b1, "rd_ctrl_lock");

        // Reset in the middle of a write: nothing may be acked or written.
        @(negedge clk);
        sel = 1'b1; req = 1'b1; addr = 32'h2000_0008; we = 1'b1; wdata = 32'hDEAD_BEEF; is_gate = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.ack", {31'd0, ack}, 32'd0);
        chk("midrst.locked", {31'd0, locked}, 32'd0);
        model_reset();
        @(negedge clk); sel = 1'b0; req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ack) seen++;
        end
        chk("midrst.noack", 32'(seen), 32'd0);
        txn(32'h2000_0008, 1'b0, 32'h0, 1'b1, "rd_after_rst");
        txn(32'h2000_0008, 1'b1, 32'h0BAD_F00D, 1'b1, "wr_after_rst");
        txn(32'h2000_0008, 1'b0, 32'h0, 1'b1, "rd_after_rst2");

        // Zero-wait instance: back-to-back transactions with req held high.
        @(negedge clk);
        sel0 = 1'b1; req0 = 1'b1; addr0 = 32'h2000_000C; we0 = 1'b1; wdata0 = 32'hA5A5_0000; is_gate0 = 1'b1;
        lat1 = 99; lat2 = 99; e1 = 1'b1; e2 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (ack0) begin lat1 = k; e1 = err0; break; end
        end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (ack0) begin lat2 = k; e2 = err0; break; end
        end
        @(negedge clk); sel0 = 1'b0; req0 = 1'b0;
        chk("w0.lat1", 32'(lat1), 32'd1);
        chk("w0.err1", {31'd0, e1}, 32'd0);
        chk("w0.lat2", 32'(lat2), 32'd2);
        chk("w0.err2", {31'd0, e2}, 32'd0);
        @(posedge clk); #1;
        chk("w0.ack_low", {31'd0, ack0}, 32'd0);
        @(negedge clk);
        sel0 = 1'b1; req0 = 1'b1; we0 = 1'b0;
        lat1 = 99;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (ack0) begin lat1 = k; break; end
        end
        chk("w0.rd_lat", 32'(lat1), 32'd1);
        chk("w0.rd_err", {31'd0, err0}, 32'd0);
        chk("w0.rdata", rdata0, 32'hA5A5_0000);
        chk("w0.locked", {31'd0, locked0}, 32'd0);
        @(negedge clk); sel0 = 1'b0; req0 = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/boreal_priv_slave.md
BOREAL_PRIV_SLAVE -- requirements
Module: boreal_priv_slave

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before ack (legal range 0-15).
REQ-002 SHALL have parameter ID_VALUE, default 32'hB0EA_1001, meaning constant returned by the ID register.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sel  input  1  interconnect PRIV-region select (sel_priv).
REQ-006 SHALL have port req  input  1  arbitrated request, held high until ack.
REQ-007 SHALL have port is_gate  input  1  active master is the gate master (arb_is_gate).
REQ-008 SHALL have port addr  input  32  arbitrated byte address; bits [4:0] used as register offset.
REQ-009 SHALL have port we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port wdata  input  32  write data.
REQ-011 SHALL have port ack  output  1  one-cycle response strobe.
REQ-012 SHALL have port err  output  1  error flag, valid only while ack=1.
REQ-013 SHALL have port rdata  output  32  read data, valid only while ack=1 with err=0 and we=0.
REQ-014 SHALL have port locked  output  1  mirror of CTRL.LOCK.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT skipped when WAIT_CYCLES=0.
REQ-016 SHALL, in IDLE with sel=1 and req=1, capture addr, we, wdata, is_gate into request registers in that cycle (cycle T).
REQ-017 SHALL assert ack for exactly one cycle, in cycle T+1+WAIT_CYCLES, using a 4-bit down-counter in WAIT.
REQ-018 SHALL accept no new request before the cycle after ack; req held high across that boundary starts a new transaction in the first IDLE cycle.
REQ-019 SHALL complete a captured transaction even if sel or req drop during WAIT (no abort).
REQ-020 SHALL provide register map: 0x00 CTRL (bit0 LOCK, set-only, other bits RW), 0x04-0x14 SCRATCH0-4 RW, 0x18 VIOL (read-only, [7:0] violation count), 0x1C ID (read-only, ID_VALUE).
REQ-021 SHALL respond err=1 with no state change when captured is_gate=0, and increment VIOL saturating at 255.
REQ-022 SHALL respond err=1 when addr[1:0]!=0 or addr[31:5]!=27'h100_0000 (region 0x2000_0000-0x2000_001F).
REQ-023 SHALL respond err=1 to any write to VIOL or ID, and to any write while LOCK=1 (including CTRL).
REQ-024 SHALL leave LOCK at 1 once set until reset; writing bit0=0 while unlocked SHALL not clear it.
REQ-025 SHALL drive rdata=0 whenever ack=0 or err=1 or the transaction is a write.
REQ-026 SHALL apply error precedence: non-gate, then misalignment/range, then read-only/lock; only non-gate increments VIOL.

Reset
REQ-027 SHALL, on rst_n=0 (asynchronous), force FSM to IDLE, ack=0, err=0, rdata=0, LOCK=0, locked=0, CTRL/SCRATCH=0, VIOL=0, counter=0.
REQ-028 SHALL abandon any in-flight transaction on reset with no ack issued afterwards for it.

Structure
REQ-029 SHALL place register offsets, ID_VALUE default, PRIV region base 4'h2 and FSM state encodings in boreal_pkg.
REQ-030 SHALL be a single module with no sub-modules; the register file is inline.

Verification
REQ-031 SHALL cover: gate write 0x2000_0004 data 0x1234_5678 at T -> ack at T+3, err=0; read back returns 0x1234_5678.
REQ-032 SHALL cover: non-gate read 0x2000_001C -> ack at T+3, err=1, rdata=0, VIOL reads 1; 300 such accesses -> VIOL reads 255.
REQ-033 SHALL cover: write CTRL=0x1 then write SCRATCH0=0xFFFF_FFFF -> second ack err=1, SCRATCH0 unchanged, locked=1.
REQ-034 SHALL cover: read 0x2000_0002 and 0x2000_0020 -> err=1 each, VIOL unchanged.
REQ-035 SHALL cover: rst_n low at T+2 of a write -> no ack, target register 0, FSM IDLE; next request acked normally.
REQ-036 SHALL cover: WAIT_CYCLES=0 with req held high -> ack at T+1, next transaction captured at T+2, ack at T+3.
